// File: rtl/lsu_pkg.sv
// Shared types and defaults for the load/store unit: opcodes, FSM states and
// stack-pointer bounds, plus a small opcode-class helper.
package lsu_pkg;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_STORE = 2'b01,
        OP_PUSH  = 2'b10,
        OP_POP   = 2'b11
    } lsu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } lsu_state_e;

    localparam logic [7:0] SP_RESET_DEF = 8'hFF;
    localparam logic [7:0] SP_LIMIT_DEF = 8'h00;

    // STORE and PUSH write memory; LOAD and POP read it.
    function automatic logic op_writes(input lsu_op_e op);
        return (op == OP_STORE) || (op == OP_PUSH);
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core-side request/response handshake bundle for the load/store unit.
interface load_store_unit_if;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [7:0] req_base;
    logic [7:0] req_offset;
    logic [7:0] req_wdata;
    logic       resp_valid;
    logic       resp_ready;
    logic [7:0] resp_rdata;
    logic       resp_err;

    modport slave (
        input  req_valid, req_op, req_base, req_offset, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

    modport master (
        output req_valid, req_op, req_base, req_offset, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/lsu_addr_gen.sv
// Combinational effective-address, next stack pointer and stack
// overflow/underflow detection for one request.
module lsu_addr_gen
    import lsu_pkg::*;
#(
    parameter logic [7:0] SP_RESET = SP_RESET_DEF,
    parameter logic [7:0] SP_LIMIT = SP_LIMIT_DEF
) (
    input  lsu_op_e    op_i,
    input  logic [7:0] base_i,
    input  logic [7:0] offset_i,
    input  logic [7:0] sp_i,
    output logic [7:0] addr_o,
    output logic [7:0] sp_next_o,
    output logic       err_o
);

    // Address and stack bookkeeping; the 8-bit sum drops the carry.
    always_comb begin
        addr_o    = 8'h00;
        sp_next_o = sp_i;
        err_o     = 1'b0;
        case (op_i)
            OP_LOAD, OP_STORE: begin
                addr_o = base_i + offset_i;
            end
            OP_PUSH: begin
                addr_o = sp_i;
                if (sp_i == SP_LIMIT) begin
                    err_o = 1'b1;
                end else begin
                    sp_next_o = sp_i - 8'd1;
                end
            end
            OP_POP: begin
                addr_o = sp_i + 8'd1;
                if (sp_i == SP_RESET) begin
                    err_o = 1'b1;
                end else begin
                    sp_next_o = sp_i + 8'd1;
                end
            end
            default: begin
                addr_o = 8'h00;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit with a descending stack: IDLE -> ACCESS (one memory cycle)
// -> RESP (held until the core takes it).
module load_store_unit
    import lsu_pkg::*;
#(
    parameter logic [7:0] SP_RESET = SP_RESET_DEF,
    parameter logic [7:0] SP_LIMIT = SP_LIMIT_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    load_store_unit_if.slave   bus,
    output logic [7:0]         sp,
    output logic [7:0]         mem_addr,
    output logic [7:0]         mem_data_in,
    output logic               mem_wr,
    output logic               mem_rd,
    input  logic [7:0]         mem_data_out
);

    lsu_state_e state_q, state_d;
    lsu_op_e    op_q;
    logic       err_q;
    logic [7:0] sp_q, sp_upd_q;
    logic [7:0] mem_addr_q, mem_data_in_q;
    logic       mem_wr_q, mem_rd_q;
    logic       resp_valid_q, resp_err_q;
    logic [7:0] resp_rdata_q;

    lsu_op_e    req_op_s;
    logic       accept_s;
    logic [7:0] ag_addr_s, ag_sp_next_s;
    logic       ag_err_s;

    assign req_op_s = lsu_op_e'(bus.req_op);
    assign accept_s = bus.req_valid && (state_q == ST_IDLE);

    lsu_addr_gen #(
        .SP_RESET (SP_RESET),
        .SP_LIMIT (SP_LIMIT)
    ) u_addr_gen (
        .op_i      (req_op_s),
        .base_i    (bus.req_base),
        .offset_i  (bus.req_offset),
        .sp_i      (sp_q),
        .addr_o    (ag_addr_s),
        .sp_next_o (ag_sp_next_s),
        .err_o     (ag_err_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) state_d = ST_ACCESS;
                else          state_d = ST_IDLE;
            end
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP: begin
                if (bus.resp_ready) state_d = ST_IDLE;
                else                state_d = ST_RESP;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath: strobes are armed at accept so they are high for ACCESS only;
    // a faulting stack op never raises a strobe, so Z is never captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q          <= OP_LOAD;
            err_q         <= 1'b0;
            sp_q          <= SP_RESET;
            sp_upd_q      <= SP_RESET;
            mem_addr_q    <= 8'h00;
            mem_data_in_q <= 8'h00;
            mem_wr_q      <= 1'b0;
            mem_rd_q      <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_err_q    <= 1'b0;
            resp_rdata_q  <= 8'h00;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        op_q          <= req_op_s;
                        err_q         <= ag_err_s;
                        sp_upd_q      <= ag_sp_next_s;
                        mem_addr_q    <= ag_addr_s;
                        mem_data_in_q <= op_writes(req_op_s) ? bus.req_wdata : 8'h00;
                        mem_wr_q      <= op_writes(req_op_s) && !ag_err_s;
                        mem_rd_q      <= !op_writes(req_op_s) && !ag_err_s;
                    end
                end
                ST_ACCESS: begin
                    mem_wr_q     <= 1'b0;
                    mem_rd_q     <= 1'b0;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= err_q;
                    resp_rdata_q <= (!op_writes(op_q) && !err_q) ? mem_data_out : 8'h00;
                    if (!err_q) begin
                        sp_q <= sp_upd_q;
                    end
                end
                ST_RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                    end
                end
                default: begin
                    mem_wr_q <= 1'b0;
                    mem_rd_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready  = (state_q == ST_IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
    assign sp             = sp_q;
    assign mem_addr       = mem_addr_q;
    assign mem_data_in    = mem_data_in_q;
    assign mem_wr         = mem_wr_q;
    assign mem_rd         = mem_rd_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench: directed stack/memory scenarios plus random traffic
// against a transaction-level reference model.
module tb_load_store_unit;

    logic       clk;
    logic       rst_n;
    logic [7:0] sp;
    logic [7:0] mem_addr;
    logic [7:0] mem_data_in;
    logic       mem_wr;
    logic       mem_rd;
    wire  [7:0] mem_data_out;

    load_store_unit_if bus ();

    load_store_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus.slave),
        .sp           (sp),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_wr       (mem_wr),
        .mem_rd       (mem_rd),
        .mem_data_out (mem_data_out)
    );

    // Data memory device: writes commit on the falling edge, reads float when idle.
    logic [7:0] mem_dev [256];
    always @(negedge clk) begin
        if (mem_wr) mem_dev[mem_addr] <= mem_data_in;
    end
    assign mem_data_out = mem_rd ? mem_dev[mem_addr] : 8'hzz;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state.
    logic [7:0] ref_mem [256];
    int         ref_sp;
    int         n_checks;
    int         n_errors;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_sp",     32'(sp), 32'hFF);
        check_val("rst_wr",     32'(mem_wr), 32'd0);
        check_val("rst_rd",     32'(mem_rd), 32'd0);
        check_val("rst_addr",   32'(mem_addr), 32'd0);
        check_val("rst_din",    32'(mem_data_in), 32'd0);
        check_val("rst_rvalid", 32'(bus.resp_valid), 32'd0);
        check_val("rst_rdata",  32'(bus.resp_rdata), 32'd0);
        check_val("rst_err",    32'(bus.resp_err), 32'd0);
        rst_n  = 1'b1;
        ref_sp = 255;
        @(posedge clk);
        #1;
        check_val("rst_ready", 32'(bus.req_ready), 32'd1);
    endtask

    // One complete transaction; the response is held 'hold' cycles before acceptance.
    task automatic run_txn(input logic [1:0] op, input logic [7:0] base, input logic [7:0] off,
                           input logic [7:0] wdata, input int hold);
        logic [7:0] e_addr, e_rdata;
        logic       e_err, e_wr, e_rd;
        e_addr = 8'h00; e_rdata = 8'h00; e_err = 1'b0; e_wr = 1'b0; e_rd = 1'b0;
        case (op)
            2'b00: begin
                e_addr = 8'((int'(base) + int'(off)) % 256);
                e_rdata = ref_mem[e_addr]; e_rd = 1'b1;
            end
            2'b01: begin
                e_addr = 8'((int'(base) + int'(off)) % 256);
                ref_mem[e_addr] = wdata; e_wr = 1'b1;
            end
            2'b10: begin
                if (ref_sp == 0) e_err = 1'b1;
                else begin
                    e_addr = 8'(ref_sp); ref_mem[e_addr] = wdata; e_wr = 1'b1; ref_sp = ref_sp - 1;
                end
            end
            default: begin
                if (ref_sp == 255) e_err = 1'b1;
                else begin
                    ref_sp = ref_sp + 1; e_addr = 8'(ref_sp); e_rdata = ref_mem[e_addr]; e_rd = 1'b1;
                end
            end
        endcase
        check_val("idle_ready", 32'(bus.req_ready), 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_op     = op;
        bus.req_base   = base;
        bus.req_offset = off;
        bus.req_wdata  = wdata;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        check_val("acc_ready", 32'(bus.req_ready), 32'd0);
        check_val("acc_wr", 32'(mem_wr), 32'(e_wr));
        check_val("acc_rd", 32'(mem_rd), 32'(e_rd));
        if (e_wr || e_rd) check_val("acc_addr", 32'(mem_addr), 32'(e_addr));
        if (e_wr) check_val("acc_din", 32'(mem_data_in), 32'(wdata));
        @(posedge clk);
        #1;
        check_val("resp_valid", 32'(bus.resp_valid), 32'd1);
        check_val("resp_rdata", 32'(bus.resp_rdata), 32'(e_rdata));
        check_val("resp_err",   32'(bus.resp_err), 32'(e_err));
        check_val("resp_sp",    32'(sp), 32'(ref_sp));
        check_val("resp_strb",  32'({mem_wr, mem_rd}), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check_val("hold_valid", 32'(bus.resp_valid), 32'd1);
            check_val("hold_rdata", 32'(bus.resp_rdata), 32'(e_rdata));
            check_val("hold_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        check_val("done_valid", 32'(bus.resp_valid), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        bus.req_op = 2'b00; bus.req_base = 8'h00; bus.req_offset = 8'h00; bus.req_wdata = 8'h00;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = 8'($urandom);
            mem_dev[i] = ref_mem[i];
        end
        do_reset();

        // POP on an empty stack must fault without touching memory.
        run_txn(2'b11, 8'h00, 8'h00, 8'h00, 0);
        // STORE/LOAD through a wrapping address.
        run_txn(2'b01, 8'hF0, 8'h20, 8'h5A, 0);
        run_txn(2'b00, 8'hF0, 8'h20, 8'h00, 0);
        // Push/pop ordering.
        run_txn(2'b10, 8'h00, 8'h00, 8'hA1, 0);
        run_txn(2'b10, 8'h00, 8'h00, 8'hB2, 0);
        run_txn(2'b11, 8'h00, 8'h00, 8'h00, 0);
        run_txn(2'b11, 8'h00, 8'h00, 8'h00, 0);
        // Backpressured LOAD.
        run_txn(2'b00, 8'h33, 8'h44, 8'h00, 5);

        // Random mixed traffic.
        for (int i = 0; i < 60; i++) begin
            run_txn(2'($urandom_range(3, 0)), 8'($urandom), 8'($urandom), 8'($urandom),
                    int'($urandom_range(2, 0)));
        end

        // Fill the stack down to the limit, then overflow.
        do_reset();
        for (int i = 0; i < 255; i++) begin
            run_txn(2'b10, 8'h00, 8'h00, 8'(i), 0);
        end
        check_val("full_sp", 32'(sp), 32'h00);
        run_txn(2'b10, 8'h00, 8'h00, 8'hEE, 0);

        // Reset in the middle of a STORE's ACCESS cycle.
        bus.req_valid  = 1'b1;
        bus.req_op     = 2'b01;
        bus.req_base   = 8'h12;
        bus.req_offset = 8'h34;
        bus.req_wdata  = 8'h77;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        check_val("mid_wr_on", 32'(mem_wr), 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("mid_wr_off", 32'(mem_wr), 32'd0);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        ref_sp = 255;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_val("mid_no_resp", 32'(bus.resp_valid), 32'd0);
            check_val("mid_sp", 32'(sp), 32'hFF);
        end
        check_val("mid_mem", 32'(mem_dev[8'h46]), 32'(ref_mem[8'h46]));
        run_txn(2'b00, 8'h12, 8'h34, 8'h00, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
